// File: rtl/character_position_ctrl_pkg.sv
// Shared types and width helpers for the character movement controller.
package char_move_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } move_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic int pos_width(input int num_pos);
        return (num_pos <= 2) ? 1 : $clog2(num_pos);
    endfunction

    // Counter only ever holds max(delay, rate)-1.
    function automatic int cnt_width(input int delay, input int rate);
        int m;
        m = (delay > rate) ? delay : rate;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/character_position_ctrl_timer.sv
// Auto-repeat down-counter: load, decrement while enabled, clear, expire flag.
module move_repeat_timer #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/character_position_ctrl.sv
// Bounded horizontal position controller: tap steps once, hold auto-repeats.
//   state     | meaning
//   ST_IDLE   | no request being tracked; next request is a fresh press
//   ST_DELAY  | pressed, waiting REPEAT_DELAY enabled cycles for first repeat
//   ST_REPEAT | repeating every REPEAT_RATE enabled cycles
module character_position_ctrl
    import char_move_pkg::*;
#(
    parameter  int NUM_POS      = 9,
    parameter  int START_POS    = 4,
    parameter  int REPEAT_DELAY = 8,
    parameter  int REPEAT_RATE  = 4,
    parameter  int WRAP         = 0,
    localparam int POS_W        = pos_width(NUM_POS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_left,
    input  logic             i_right,
    input  logic             i_enable,
    output logic [POS_W-1:0] o_curr_state,
    output logic             o_at_left,
    output logic             o_at_right,
    output logic             o_moved,
    output logic             o_move_dir
);

    localparam int               CNT_W    = cnt_width(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);
    localparam logic [POS_W-1:0] START_V  = POS_W'(START_POS);
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             START_AT_LEFT  = (START_POS == 0);
    localparam logic             START_AT_RIGHT = (START_POS == NUM_POS - 1);

    if (NUM_POS < 2) begin : g_chk_num_pos
        $error("character_position_ctrl: NUM_POS must be >= 2");
    end
    if (START_POS < 0 || START_POS >= NUM_POS) begin : g_chk_start_pos
        $error("character_position_ctrl: START_POS must be < NUM_POS");
    end
    if (REPEAT_DELAY < 1) begin : g_chk_delay
        $error("character_position_ctrl: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_RATE < 1) begin : g_chk_rate
        $error("character_position_ctrl: REPEAT_RATE must be >= 1");
    end

    move_state_t      r_state;
    logic             r_dir;
    logic [POS_W-1:0] r_pos;
    logic             r_at_left;
    logic             r_at_right;
    logic             r_moved;
    logic             r_move_dir;

    logic             w_req_l;
    logic             w_req_r;
    logic             w_req;
    logic             w_fresh;
    logic             w_same;
    logic             w_rep_step;
    logic             w_step;
    logic             w_expired;
    logic             w_tmr_clr;
    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic [CNT_W-1:0] w_tmr_val;
    logic [POS_W-1:0] w_next_pos;
    logic             w_eff;

    // Both buttons together cancel out, same as neither.
    assign w_req_l    = i_left & ~i_right;
    assign w_req_r    = i_right & ~i_left;
    assign w_req      = w_req_l | w_req_r;
    assign w_fresh    = i_enable & w_req & ((r_state == ST_IDLE) || (w_req_r != r_dir));
    assign w_same     = i_enable & w_req & (r_state != ST_IDLE) & (w_req_r == r_dir);
    assign w_rep_step = w_same & w_expired;
    assign w_step     = w_fresh | w_rep_step;

    assign w_tmr_clr  = ~i_enable | ~w_req;
    assign w_tmr_load = w_step;
    assign w_tmr_val  = w_fresh ? DELAY_LD : RATE_LD;
    assign w_tmr_dec  = w_same & ~w_expired;

    move_repeat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_tmr_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_expired)
    );

    // A blocked step at a saturated end is not an effective step.
    always_comb begin
        w_next_pos = r_pos;
        w_eff      = 1'b0;
        if (w_step) begin
            if (w_req_r) begin
                if (r_pos != LAST_POS) begin
                    w_next_pos = r_pos + POS_W'(1);
                    w_eff      = 1'b1;
                end else if (WRAP != 0) begin
                    w_next_pos = '0;
                    w_eff      = 1'b1;
                end
            end else begin
                if (r_pos != '0) begin
                    w_next_pos = r_pos - POS_W'(1);
                    w_eff      = 1'b1;
                end else if (WRAP != 0) begin
                    w_next_pos = LAST_POS;
                    w_eff      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_dir      <= DIR_LEFT;
            r_pos      <= START_V;
            r_at_left  <= START_AT_LEFT;
            r_at_right <= START_AT_RIGHT;
            r_moved    <= 1'b0;
            r_move_dir <= DIR_LEFT;
        end else begin
            r_moved <= w_eff;
            if (w_eff) begin
                r_pos      <= w_next_pos;
                r_move_dir <= w_req_r;
                r_at_left  <= (w_next_pos == '0);
                r_at_right <= (w_next_pos == LAST_POS);
            end
            if (!i_enable || !w_req) begin
                r_state <= ST_IDLE;
            end else if (w_fresh) begin
                r_state <= ST_DELAY;
                r_dir   <= w_req_r;
            end else if (w_rep_step) begin
                r_state <= ST_REPEAT;
            end
        end
    end

    assign o_curr_state = r_pos;
    assign o_at_left    = r_at_left;
    assign o_at_right   = r_at_right;
    assign o_moved      = r_moved;
    assign o_move_dir   = r_move_dir;

endmodule

// File: doc/character_position_ctrl.md
# character_position_ctrl

Parametrised horizontal position controller for the player character. It turns the left and right button levels into a bounded position index. Each tap moves one step immediately, and a held button auto-repeats after an initial delay. It supports either saturation or wrap-around at the ends. It sits between the debounced button inputs and the sprite renderer, and it generalises the fixed 9-position, tap-only character movement FSM.

## Interface
- NUM_POS, 9, number of positions (>=2)
- START_POS, 4, position loaded on reset (<NUM_POS)
- REPEAT_DELAY, 8, enabled cycles from press-step to first repeat step (>=1)
- REPEAT_RATE, 4, enabled cycles between subsequent repeat steps (>=1)
- WRAP, 0, 0 = saturate at ends, 1 = wrap 0<->NUM_POS-1
- POS_W, $clog2(NUM_POS), position width (derived, not overridden)
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- LeftIn  in  1  left button level, active-high, already synchronised
- RightIn  in  1  right button level, active-high, already synchronised
- Enable  in  1  movement enable (game running); 0 = paused
- CurrState  out  POS_W  registered current position
- AtLeft  out  1  registered, CurrState==0
- AtRight  out  1  registered, CurrState==NUM_POS-1
- Moved  out  1  one-cycle pulse, high in the cycle CurrState has just changed
- MoveDir  out  1  direction of last step (0 left, 1 right); holds between steps

## Operation
- Request decode: exactly one of LeftIn/RightIn high = request in that direction. Both high or neither high = no request.
- FSM states: IDLE, DELAY, REPEAT. A direction register holds the active direction. A repeat counter is sized for max(REPEAT_DELAY, REPEAT_RATE).
- IDLE + request: step now, latch direction, load counter with REPEAT_DELAY-1, go to DELAY.
- DELAY/REPEAT + same-direction request: decrement the counter. At 0, step, load REPEAT_RATE-1, and go to (or stay in) REPEAT.
- DELAY/REPEAT + opposite request: treated as a fresh press. Step the opposite way now, latch direction, load REPEAT_DELAY-1, go to DELAY.
- DELAY/REPEAT + no request: go to IDLE. No step.
- Enable=0: no step, FSM forced to IDLE, counter cleared. A request still held when Enable returns to 1 is a fresh press.
- Step left at 0 / right at NUM_POS-1:
  - WRAP=0: position is unchanged, Moved stays 0, MoveDir is unchanged, and FSM/counter sequencing continues normally.
  - WRAP=1: position goes to NUM_POS-1 or 0 respectively, Moved=1.
- All other steps: position ±1, Moved=1, MoveDir=direction.
- Async reset (any time, including mid-hold):
  - CurrState=START_POS, AtLeft=(START_POS==0), AtRight=(START_POS==NUM_POS-1), Moved=0, MoveDir=0.
  - FSM=IDLE, counter=0.
  - A request held through reset release is a fresh press at the first enabled edge.

## Timing
- Press sampled at edge t0: CurrState, AtLeft, AtRight, Moved and MoveDir update at t0, giving one-edge latency.
- With a continuous hold and Enable=1, steps occur at edges t0, t0+REPEAT_DELAY, and t0+REPEAT_DELAY+k*REPEAT_RATE.
- Moved is high for exactly the cycle after each effective step edge.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package char_move_pkg:
  - FSM state encoding (IDLE/DELAY/REPEAT)
  - DIR_LEFT=0 / DIR_RIGHT=1 constants
  - position/counter width helper functions
- One sub-module, move_repeat_timer: load value, decrement-when-enabled, clear, and expire flag. The FSM and position register stay in the top.
- Parameter legality is checked at elaboration: NUM_POS>=2, START_POS<NUM_POS, REPEAT_DELAY>=1, REPEAT_RATE>=1.

## Test plan
All scenarios use defaults unless stated.
- Reset: assert Reset=0 mid-clock -> immediately CurrState=4, AtLeft=0, AtRight=0, Moved=0, MoveDir=0.
- Single tap: RightIn high for 1 cycle from position 4 -> CurrState=5 after one edge, Moved high 1 cycle, MoveDir=1, no further step over 20 cycles.
- Hold: LeftIn held 24 cycles from 4 -> steps at t0, t0+8, t0+12, t0+16 giving 3, 2, 1, 0. At t0+20, position stays 0, AtLeft=1, Moved=0.
- Wrap (WRAP=1): at position 8, tap RightIn -> CurrState=0, Moved=1, MoveDir=1, AtLeft=1. Tap LeftIn -> 8.
- Conflicts: LeftIn and RightIn both high -> no change for 10 cycles. Drop LeftIn while RightIn stays high -> immediate step right, next repeat 8 cycles later.
- Pause/reset mid-hold:
  - Hold RightIn, drop Enable for 5 cycles -> no steps; on re-enable, immediate step, then the delay restarts.
  - Reset mid-hold -> CurrState=4; first edge after release steps to 5.
